mini_lab0: RTL and testbench
============================

Name: mini_lab0

Overview:
- Switch-driven LED demo engine for the lab board top level.
- Synchronizes the 10 slide switches; SW[9:8] selects one of four display modes; SW[7:0] supplies the operand or seed.
- A single 10-bit state register drives the 10 red LEDs directly.
- A parameterised prescaler produces the slow "tick" that advances the counter, LFSR and accumulator modes.

Parameters:
- TICK_DIV, 16, clock cycles per tick; legal range 2..65535.

Ports:
- clk   input  1   system clock; all logic on the rising edge.
- KEY0  input  1   reset; synchronous, active-high.
- SW    input  10  asynchronous slide switches; [9:8] = mode, [7:0] = operand.
- LEDR  output 10  LED drive; equals the state register (registered output).

Behaviour:
- Synchronizer
  - All 10 SW bits pass through a 2-flop synchronizer; sw_s is the second stage.
  - mode = sw_s[9:8].
- Reset (KEY0=1 at a rising edge)
  - Sync flops = 0, mode_prev = 2'b00, prescaler = 0, state = 0, so LEDR = 0.
  - Reset has priority over everything, including mid-operation.
- Prescaler
  - pcnt counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly the cycle in which pcnt == TICK_DIV-1.
- Mode change
  - mode_prev <= mode every cycle.
  - When mode != mode_prev: pcnt <= 0 and state is loaded with the entry value for the new mode.
  - A mode change has priority over tick in the same cycle.
- Mode 00, pass-through
  - state <= sw_s every cycle; tick is ignored.
  - Total latency SW to LEDR is 3 rising edges.
- Mode 01, up-counter
  - Entry value 0.
  - On tick: state <= state + 1, wrapping 1023 -> 0.
- Mode 10, LFSR
  - Entry value {2'b11, sw_s[7:0]}, which is never zero.
  - On tick: state <= {state[8:0], state[9]^state[6]} (x^10 + x^7 + 1 Fibonacci).
  - SW[7:0] changes after entry have no effect until the next entry.
- Mode 11, saturating accumulator
  - Entry value 0.
  - On tick: state <= min(state + sw_s[7:0], 1023). Use an 11-bit internal sum and clamp at 10'h3FF.
  - Operand changes take effect on the next tick after synchronization.
- Modes 01–11: state holds its value in non-tick cycles.
- No combinational path from SW to LEDR.
- All widths unsigned.

Test Plan:
- Reset: SW=10'h2AA, hold KEY0=1 for 5 cycles, including once mid-count in mode 01 -> LEDR=0 on every cycle while KEY0=1; pcnt restarts from 0 after release.
- Pass-through: KEY0 0, SW=10'h0A5 -> LEDR=0x0A5 by the 3rd edge after SW changes; change SW to 10'h05A -> LEDR=0x05A exactly 3 edges later.
- Counter: SW=10'h100, TICK_DIV=16 -> on mode entry LEDR=0.
  - Then 1,2,3… at intervals of exactly 16 cycles.
  - Force state=1023 -> the next tick gives 0.
- LFSR: SW=10'h2AA -> entry LEDR=0x3AA; first tick 0x355; the sequence never reaches 0 over 1023 ticks and repeats with period 1023.
- Accumulator: SW=10'h3C8 (operand 200) -> LEDR 0,200,400,600,800,1000,1023,1023… on successive ticks.
- Mode switch mid-tick: in mode 01 at LEDR=5, pcnt=9, set SW[9:8]=11 -> state=0 and pcnt=0 on entry; the first accumulate happens exactly 16 cycles later, and no stray tick occurs on the entry cycle.

Source files
------------

// File: rtl/mini_lab0.sv
// Lab-board LED demo engine: synchronized switches pick one of four display
// modes (pass-through, counter, LFSR, saturating accumulator) that drive LEDR.
module mini_lab0 #(
    parameter int TICK_DIV = 16
) (
    input  logic       clk,
    input  logic       KEY0,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        M_PASS = 2'b00,
        M_CNT  = 2'b01,
        M_LFSR = 2'b10,
        M_ACC  = 2'b11
    } mode_t;

    logic [9:0]    sw_m, sw_s;
    mode_t         mode, mode_prev;
    logic [PW-1:0] pcnt;
    logic          tick, mode_chg;
    logic [9:0]    state, entry, lfsr_nx, acc_nx;
    logic [10:0]   acc_sum;

    assign mode     = mode_t'(sw_s[9:8]);
    assign tick     = (pcnt == PLAST);
    assign mode_chg = (mode != mode_prev);

    // 11-bit sum: state <= 1023 and operand <= 255, so bit 10 flags overflow
    assign acc_sum = {1'b0, state} + {3'b000, sw_s[7:0]};
    assign acc_nx  = acc_sum[10] ? 10'h3FF : acc_sum[9:0];
    assign lfsr_nx = {state[8:0], state[9] ^ state[6]};

    always_comb begin
        entry = '0;
        case (mode)
            M_PASS:  entry = sw_s;
            M_LFSR:  entry = {2'b11, sw_s[7:0]};
            default: entry = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (KEY0) begin
            sw_m      <= '0;
            sw_s      <= '0;
            mode_prev <= M_PASS;
            pcnt      <= '0;
            state     <= '0;
        end else begin
            sw_m      <= SW;
            sw_s      <= sw_m;
            mode_prev <= mode;
            // entering a mode restarts the prescaler and masks any coincident tick
            if (mode_chg) begin
                pcnt  <= '0;
                state <= entry;
            end else begin
                pcnt <= tick ? '0 : pcnt + 1'b1;
                case (mode)
                    M_PASS: state <= sw_s;
                    M_CNT:  if (tick) state <= state + 10'd1;
                    M_LFSR: if (tick) state <= lfsr_nx;
                    M_ACC:  if (tick) state <= acc_nx;
                    default: state <= state;
                endcase
            end
        end
    end

    assign LEDR = state;

endmodule

// File: tb/tb_mini_lab0.sv
module tb_mini_lab0;
    logic       clk = 1'b0;
    logic       KEY0;
    logic [9:0] SW;
    logic [9:0] LEDR;

    mini_lab0 #(.TICK_DIV(16)) dut (
        .clk (clk),
        .KEY0(KEY0),
        .SW  (SW),
        .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sw;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        int         at;
        logic [9:0] val;
        string      nm;
    } sb_t;

    sb_t  sbq[$];
    sb_t  me;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            me = sbq.pop_front();
            nvec++;
            if (LEDR !== me.val) begin
                nerr++;
                $display("FAIL %s @cyc %0d: LEDR=%h expected %h", me.nm, cyc, LEDR, me.val);
            end
        end
    end

    task automatic push(input int at, input logic [9:0] v, input string nm);
        sb_t e;
        e.at  = at;
        e.val = v;
        e.nm  = nm;
        sbq.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [9:0] lfsr_step(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cyc=%0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t pass_tbl[6];
        vec_t acc_tbl[8];
        logic [9:0] lf;
        int c, d, e, a, r0, r;

        pass_tbl = '{'{10'h0A5, 10'h0A5}, '{10'h05A, 10'h05A}, '{10'h0FF, 10'h0FF},
                     '{10'h000, 10'h000}, '{10'h0C3, 10'h0C3}, '{10'h03C, 10'h03C}};
        acc_tbl  = '{'{10'h3C8, 10'd0},   '{10'h3C8, 10'd200},  '{10'h3C8, 10'd400},
                     '{10'h3C8, 10'd600}, '{10'h3C8, 10'd800},  '{10'h3C8, 10'd1000},
                     '{10'h3C8, 10'd1023}, '{10'h3C8, 10'd1023}};

        KEY0 = 1'b1;
        SW   = 10'h2AA;
        for (int i = 1; i <= 5; i++) push(i, 10'h000, "rst_hold");
        c = 5;
        push(c + 1, 10'h000, "rst_sync1");
        push(c + 2, 10'h000, "rst_sync2");
        push(c + 3, 10'h3AA, "lfsr_entry");
        push(c + 19, 10'h355, "lfsr_first");
        lf = 10'h3AA;
        for (int k = 1; k <= 1023; k++) begin
            lf = lfsr_step(lf);
            push(c + 3 + 16 * k, lf, "lfsr_seq");
        end
        push(c + 3 + 16 * 1023, 10'h3AA, "lfsr_period");
        wait_until(5);
        if (LEDR !== 10'h000) begin
            nerr++;
            $display("FAIL rst_direct @cyc %0d: LEDR=%h expected 000", cyc, LEDR);
        end
        KEY0 = 1'b0;
        wait_until(c + 3 + 16 * 100 + 5);
        SW = 10'h2FF;
        wait_until(c + 3 + 16 * 1023 + 1);

        for (int i = 0; i < 6; i++) begin
            d  = cyc;
            SW = pass_tbl[i].sw;
            if (i > 0) push(d + 2, pass_tbl[i-1].exp, "pass_hold");
            push(d + 3, pass_tbl[i].exp, "pass");
            wait_until(d + 4);
        end
        if (LEDR !== 10'h03C) begin
            nerr++;
            $display("FAIL pass_direct @cyc %0d: LEDR=%h expected 03c", cyc, LEDR);
        end

        d  = cyc;
        SW = 10'h100;
        e  = d + 3;
        push(e, 10'd0, "cnt_entry");
        push(e + 15, 10'd0, "cnt_hold0");
        for (int k = 1; k <= 1024; k++) begin
            push(e + 16 * k, 10'(k), "cnt_tick");
            if (k <= 3) push(e + 16 * k + 8, 10'(k), "cnt_hold");
        end
        wait_until(e + 16 * 1026 + 5);

        r0   = cyc;
        KEY0 = 1'b1;
        for (int i = 1; i <= 5; i++) push(r0 + i, 10'd0, "rst_mid");
        wait_until(r0 + 5);
        KEY0 = 1'b0;
        r = cyc;
        e = r + 3;
        push(r + 1, 10'd0, "rst_rel1");
        push(r + 2, 10'd0, "rst_rel2");
        push(e, 10'd0, "cnt_reentry");
        push(e + 15, 10'd0, "cnt_pcnt0");
        push(e + 16, 10'd1, "cnt_after_rst");
        push(e + 80, 10'd5, "cnt_five");

        push(e + 89, 10'd5, "sw_pre");
        push(e + 90, 10'd0, "acc_entry_mid");
        push(e + 105, 10'd0, "no_stray_tick");
        push(e + 106, 10'd7, "acc_first");
        push(e + 122, 10'd14, "acc_second");
        wait_until(e + 87);
        SW = 10'h307;
        wait_until(e + 123);

        d  = cyc;
        SW = 10'h000;
        push(d + 3, 10'd0, "pass_reenter");
        wait_until(d + 4);
        d  = cyc;
        SW = acc_tbl[0].sw;
        a  = d + 3;
        for (int k = 0; k < 8; k++) push(a + 16 * k, acc_tbl[k].exp, "acc_tbl");
        push(a + 143, 10'd1023, "acc_sat");
        push(a + 144, 10'h3C8, "prio_entry");
        push(a + 159, 10'h3C8, "prio_hold");
        push(a + 160, lfsr_step(10'h3C8), "prio_first_tick");
        wait_until(a + 141);
        SW = 10'h2C8;
        wait_until(a + 161);

        for (int i = 0; i < 300 && sbq.size() > 0; i++) @(posedge clk);
        while (sbq.size() > 0) begin
            me = sbq.pop_front();
            nvec++;
            nerr++;
            $display("FAIL %s @cyc %0d: never checked, expected %h", me.nm, me.at, me.val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        if (nerr != 0) $display("FAIL: %0d errors", nerr);
        else $display("PASS");
        $finish;
    end

endmodule
